// File: rtl/pc_unit.sv
// Program counter: picks pc+4, branch/JAL target, JALR target or trap vector and runs the boot/run/trap FSM.
// Latency: next PC is registered one cycle after the decision; o_pc_plus4 is combinational.
// Backpressure: i_stall freezes the PC and suppresses traps. Optional taken counter under PC_BRANCH_COUNT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pc_unit #(
    parameter logic [`DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [`DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int                     IALIGN       = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_stall,
    input  logic                   i_take,
    input  logic                   i_jalr,
    input  logic [`DATA_WIDTH-1:0] i_imm,
    input  logic [`DATA_WIDTH-1:0] i_rs1,
    input  logic                   i_trap_ack,
    output logic [`DATA_WIDTH-1:0] o_pc,
    output logic [`DATA_WIDTH-1:0] o_pc_plus4,
    output logic                   o_valid,
    output logic                   o_misaligned,
    output logic [`DATA_WIDTH-1:0] o_bad_addr,
`ifdef PC_BRANCH_COUNT_EN
    output logic [31:0]            o_taken_cnt,
`endif
    output logic [1:0]             o_state
);

    localparam int W = `DATA_WIDTH;
    localparam logic [1:0] S_BOOT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_TRAP = 2'b10;
    localparam logic [W-1:0] ALIGN_MASK = W'(IALIGN - 1);
    localparam logic [W-1:0] FOUR       = W'(4);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [W-1:0] r_pc;
    logic [W-1:0] r_bad_addr;
    logic         r_misaligned;
    logic [W-1:0] w_target;
    logic         w_advance;
    logic         w_misal;
    logic         w_trap;
    logic         w_commit;

    // JALR clears bit 0 before the alignment check, so with IALIGN=2 it can never trap.
    assign w_target  = i_jalr ? ((i_rs1 + i_imm) & {{(W-1){1'b1}}, 1'b0}) : (r_pc + i_imm);
    assign w_advance = (r_state == S_RUN) && !i_stall;
    assign w_misal   = |(w_target & ALIGN_MASK);
    assign w_trap    = w_advance && i_take && w_misal;
    assign w_commit  = w_advance && i_take && !w_misal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_BOOT;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = S_BOOT;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = w_trap ? S_TRAP : S_RUN;
            S_TRAP:  w_state_nxt = i_trap_ack ? S_RUN : S_TRAP;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        o_valid = (r_state == S_RUN);
        o_state = r_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc         <= RESET_VECTOR;
            r_bad_addr   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_trap;
            if (w_trap) begin
                r_pc       <= TRAP_VECTOR;
                r_bad_addr <= w_target;
            end else if (w_commit) begin
                r_pc <= w_target;
            end else if (w_advance) begin
                r_pc <= r_pc + FOUR;
            end
        end
    end

`ifdef PC_BRANCH_COUNT_EN
    logic [31:0] r_taken_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                            r_taken_cnt <= '0;
        else if (w_commit && ~&r_taken_cnt)      r_taken_cnt <= r_taken_cnt + 32'd1;
    end
    assign o_taken_cnt = r_taken_cnt;
`endif

    assign o_pc         = r_pc;
    assign o_pc_plus4   = r_pc + FOUR;
    assign o_misaligned = r_misaligned;
    assign o_bad_addr   = r_bad_addr;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: boot, sequential fetch, branches, JALR trap, stall, wrap and mid-trap reset.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_pc_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_take = 1'b0;
    logic        i_jalr = 1'b0;
    logic [31:0] i_imm = '0;
    logic [31:0] i_rs1 = '0;
    logic        i_trap_ack = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic        o_misaligned;
    logic [31:0] o_bad_addr;
    logic [1:0]  o_state;
`ifdef PC_BRANCH_COUNT_EN
    logic [31:0] o_taken_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    pc_unit dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_stall      (i_stall),
        .i_take       (i_take),
        .i_jalr       (i_jalr),
        .i_imm        (i_imm),
        .i_rs1        (i_rs1),
        .i_trap_ack   (i_trap_ack),
        .o_pc         (o_pc),
        .o_pc_plus4   (o_pc_plus4),
        .o_valid      (o_valid),
        .o_misaligned (o_misaligned),
        .o_bad_addr   (o_bad_addr),
`ifdef PC_BRANCH_COUNT_EN
        .o_taken_cnt  (o_taken_cnt),
`endif
        .o_state      (o_state)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic set_in(input logic stall, input logic take, input logic jalr,
                          input logic [31:0] imm, input logic [31:0] rs1, input logic ack);
        i_stall = stall; i_take = take; i_jalr = jalr;
        i_imm = imm; i_rs1 = rs1; i_trap_ack = ack;
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        check_vec("rst_pc",    o_pc, 32'h0);
        check_vec("rst_valid", 32'(o_valid), 32'd0);
        check_vec("rst_mis",   32'(o_misaligned), 32'd0);
        check_vec("rst_bad",   o_bad_addr, 32'h0);
        check_vec("rst_state", 32'(o_state), 32'd0);
        i_rst_n = 1'b1;
        check_vec("boot_pc",    o_pc, 32'h0);
        check_vec("boot_valid", 32'(o_valid), 32'd0);

        // sequential fetch 0, 4, 8, C, 10
        tick(); check_vec("seq0_pc", o_pc, 32'h0); check_vec("seq0_valid", 32'(o_valid), 32'd1);
        check_vec("seq0_state", 32'(o_state), 32'd1);
        tick(); check_vec("seq1_pc", o_pc, 32'h4);
        tick(); check_vec("seq2_pc", o_pc, 32'h8);
        check_vec("seq2_plus4", o_pc_plus4, 32'hC);
        tick(); tick(); check_vec("seq4_pc", o_pc, 32'h10);

        // backward branch 0x10 + -8 -> 0x08
        set_in(0, 1, 0, 32'hFFFF_FFF8, 32'h0, 0);
        tick(); check_vec("br_back_pc", o_pc, 32'h8);
        check_vec("br_back_mis", 32'(o_misaligned), 32'd0);

        // JALR to 0x1003 -> 0x1002, misaligned for IALIGN=4
        set_in(0, 1, 1, 32'h0, 32'h1003, 0);
        tick();
        check_vec("jalr_mis",   32'(o_misaligned), 32'd1);
        check_vec("jalr_bad",   o_bad_addr, 32'h1002);
        check_vec("jalr_pc",    o_pc, 32'h100);
        check_vec("jalr_state", 32'(o_state), 32'd2);
        check_vec("jalr_valid", 32'(o_valid), 32'd0);

        // take/stall ignored in TRAP
        set_in(1, 1, 0, 32'h8, 32'h0, 0);
        tick();
        check_vec("trap_mis_clr", 32'(o_misaligned), 32'd0);
        check_vec("trap_hold_pc", o_pc, 32'h100);
        check_vec("trap_hold_st", 32'(o_state), 32'd2);
        check_vec("trap_hold_bad", o_bad_addr, 32'h1002);
        set_in(0, 0, 0, 32'h0, 32'h0, 1);
        tick();
        check_vec("ack_state", 32'(o_state), 32'd1);
        check_vec("ack_valid", 32'(o_valid), 32'd1);
        check_vec("ack_pc",    o_pc, 32'h100);

        // branch to 0x20, then stall with take for 2 cycles
        set_in(0, 1, 0, 32'hFFFF_FF20, 32'h0, 0);
        tick(); check_vec("br_20_pc", o_pc, 32'h20);
        set_in(1, 1, 0, 32'h40, 32'h0, 0);
        tick(); check_vec("stall1_pc", o_pc, 32'h20);
        tick(); check_vec("stall2_pc", o_pc, 32'h20);
        check_vec("stall2_mis", 32'(o_misaligned), 32'd0);
        i_stall = 1'b0;
        tick(); check_vec("unstall_pc", o_pc, 32'h60);

        // stalled misaligned take must not trap
        set_in(1, 1, 0, 32'h2, 32'h0, 0);
        tick();
        check_vec("stall_mis_pc",  o_pc, 32'h60);
        check_vec("stall_mis_st",  32'(o_state), 32'd1);
        check_vec("stall_mis_mis", 32'(o_misaligned), 32'd0);

        // wrap at top of address space
        set_in(0, 1, 0, 32'hFFFF_FF9C, 32'h0, 0);
        tick();
        check_vec("top_pc",    o_pc, 32'hFFFF_FFFC);
        check_vec("top_plus4", o_pc_plus4, 32'h0);
        set_in(0, 0, 0, 32'h0, 32'h0, 0);
        tick(); check_vec("wrap_pc", o_pc, 32'h0);

        // trap_ack in RUN ignored while take commits
        set_in(0, 1, 0, 32'h10, 32'h0, 1);
        tick();
        check_vec("ack_run_pc", o_pc, 32'h10);
        check_vec("ack_run_st", 32'(o_state), 32'd1);

        // PC-relative misaligned target 0x10 + 6 = 0x16
        set_in(0, 1, 0, 32'h6, 32'h0, 0);
        tick();
        check_vec("br_mis_bad", o_bad_addr, 32'h16);
        check_vec("br_mis_pc",  o_pc, 32'h100);
        check_vec("br_mis_st",  32'(o_state), 32'd2);
        set_in(0, 0, 0, 32'h0, 32'h0, 0);
        tick();
        check_vec("wait_pc", o_pc, 32'h100);

`ifdef PC_BRANCH_COUNT_EN
        check_vec("taken_cnt", o_taken_cnt, 32'd5);
`endif

        // reset mid-trap takes effect without a clock edge
        #2 i_rst_n = 1'b0;
        #1;
        check_vec("mid_rst_pc",    o_pc, 32'h0);
        check_vec("mid_rst_state", 32'(o_state), 32'd0);
        check_vec("mid_rst_bad",   o_bad_addr, 32'h0);
        check_vec("mid_rst_valid", 32'(o_valid), 32'd0);
`ifdef PC_BRANCH_COUNT_EN
        check_vec("mid_rst_cnt",   o_taken_cnt, 32'd0);
`endif
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        check_vec("reboot_pc",    o_pc, 32'h0);
        check_vec("reboot_state", 32'(o_state), 32'd1);
        tick();
        check_vec("reboot_seq",   o_pc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
